seg7_display_driver: RTL

SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

---
 rtl/seg7_display_driver.sv | 115 +++++++++++
 1 files changed

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: latches a 14-bit value and drives four active-low 7-segment digits
//   iCLK   : clock, rising edge
//   iRST   : asynchronous active-high reset
//   iLOAD  : load strobe, accepted only while idle
//   iHEX   : 1 = hexadecimal, 0 = decimal (sampled with iLOAD)
//   iVALUE : 14-bit binary value (sampled with iLOAD)
//   oSEG   : digits 3..0, 7 bits each, gfedcba, active low
//   oBUSY  : high while a load is in flight
//   oDONE  : one-cycle pulse when oSEG updates
//   oOVF   : last decimal load exceeded 9999
module seg7_display_driver #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iLOAD,
    input  logic        iHEX,
    input  logic [13:0] iVALUE,
    output logic [27:0] oSEG,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oOVF
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t      state;
    logic [13:0] binReg;
    logic        hexReg;
    logic        ovfReg;
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic [15:0] adj;
    logic [15:0] nibbles;
    logic [3:0]  blank;
    logic [27:0] segNext;
    logic        tooBig;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: segOf = 7'b1000000;
            4'h1: segOf = 7'b1111001;
            4'h2: segOf = 7'b0100100;
            4'h3: segOf = 7'b0110000;
            4'h4: segOf = 7'b0011001;
            4'h5: segOf = 7'b0010010;
            4'h6: segOf = 7'b0000010;
            4'h7: segOf = 7'b1111000;
            4'h8: segOf = 7'b0000000;
            4'h9: segOf = 7'b0011000;
            4'hA: segOf = 7'b0001000;
            4'hB: segOf = 7'b0000011;
            4'hC: segOf = 7'b1000110;
            4'hD: segOf = 7'b0100001;
            4'hE: segOf = 7'b0000110;
            default: segOf = 7'b0001110;
        endcase
    endfunction

    assign tooBig = iVALUE > 14'd9999;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        // in decimal mode binReg has been shifted out, so hex is the only user of it here
        nibbles = hexReg ? {2'b00, binReg} : bcd;
        blank[0] = 1'b0;
        blank[3] = (BLANK_LEADING != 0) && nibbles[15:12] == 4'd0;
        blank[2] = blank[3] && nibbles[11:8] == 4'd0;
        blank[1] = blank[2] && nibbles[7:4] == 4'd0;
        segNext = '1;
        for (int i = 0; i < 4; i++)
            segNext[7*i +: 7] = ovfReg ? 7'b0111111 : blank[i] ? 7'b1111111 : segOf(nibbles[4*i +: 4]);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            binReg <= '0;
            hexReg <= 1'b0;
            ovfReg <= 1'b0;
            bcd    <= '0;
            cnt    <= '0;
            oSEG   <= 28'hFFFFFFF;
            oBUSY  <= 1'b0;
            oDONE  <= 1'b0;
            oOVF   <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            case (state)
                IDLE: if (iLOAD) begin
                    binReg <= iVALUE;
                    hexReg <= iHEX;
                    ovfReg <= !iHEX && tooBig;
                    bcd    <= '0;
                    cnt    <= '0;
                    state  <= (iHEX || tooBig) ? UPDATE : CONV;
                    oBUSY  <= 1'b1;
                end
                CONV: begin
                    {bcd, binReg} <= {adj, binReg} << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) state <= UPDATE;
                end
                default: begin
                    oSEG  <= segNext;
                    oOVF  <= ovfReg;
                    oDONE <= 1'b1;
                    oBUSY <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
